// File: rtl/icache_pkg.sv
// Purpose: shared widths, constants and FSM encoding for the instruction cache.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package icache_pkg;

  localparam int AddrLen = 32;
  localparam int InstLen = 32;

  // Default geometry: 2^7 lines of one 32-bit word each.
  localparam int ICACHE_INDEX_BITS = 7;

  localparam logic [InstLen-1:0] ZERO_WORD = '0;

  // addr[17:16] == 2'b11 selects the memory-mapped IO window, which is never cached.
  localparam logic [1:0] IO_REGION = 2'b11;

  typedef enum logic [1:0] {
    ICACHE_IDLE = 2'd0,
    ICACHE_MISS = 2'd1,
    ICACHE_RESP = 2'd2
  } icache_state_e;

  function automatic logic is_uncached(input logic [AddrLen-1:0] addr);
    return addr[17:16] == IO_REGION;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Purpose: tag/data/valid storage for the direct-mapped icache; one async read port, one write port.
// Latency: read is combinational; a write becomes visible the cycle after wr_en.
// Backpressure: none; the caller gates wr_en.
// Ports: clk/rst (sync, active-high, clears all valid bits), rd_idx -> rd_valid/rd_tag/rd_data,
//        wr_en/wr_idx/wr_tag/wr_data fill a line and mark it valid.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = 16 - ICACHE_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [InstLen-1:0]    rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [InstLen-1:0]    wr_data
);

  localparam int Lines = 1 << INDEX_BITS;

  logic [Lines-1:0]    valid_q;
  logic [Lines-1:0]    valid_d;
  logic [TAG_BITS-1:0] tag_mem  [Lines];
  logic [InstLen-1:0]  data_mem [Lines];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag/data carry no reset so they can map onto RAM; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Purpose: direct-mapped, one-word-per-line instruction cache between IF and the memory controller.
// Latency: hit -> if_enable one cycle after the request; miss -> if_enable one cycle after mc_enable.
// Backpressure: rdy low freezes everything; jump_or_not aborts any in-flight miss without a response.
// Ports: clk, rst (sync active-high), rdy, jump_or_not; IF side if_request/if_addr -> if_inst/if_enable;
//        memory side mc_request/mc_addr -> mc_inst/mc_enable.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = 16 - INDEX_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               jump_or_not,
  input  logic               if_request,
  input  logic [AddrLen-1:0] if_addr,
  output logic [InstLen-1:0] if_inst,
  output logic               if_enable,
  output logic               mc_request,
  output logic [AddrLen-1:0] mc_addr,
  input  logic [InstLen-1:0] mc_inst,
  input  logic               mc_enable
);

  icache_state_e         state_q, state_d;
  logic [InstLen-1:0]    if_inst_q, if_inst_d;
  logic                  if_enable_q, if_enable_d;
  logic                  mc_request_q, mc_request_d;
  logic [AddrLen-1:0]    mc_addr_q, mc_addr_d;
  logic [INDEX_BITS-1:0] req_idx_q, req_idx_d;
  logic [TAG_BITS-1:0]   req_tag_q, req_tag_d;
  logic                  req_uncached_q, req_uncached_d;

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [InstLen-1:0]    rd_data;
  logic                  hit;
  logic                  fill_en;

  // Fetch PCs are word aligned; the byte-offset bits carry no information.
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^if_addr[1:0];

  assign lookup_idx = if_addr[INDEX_BITS+1:2];
  assign lookup_tag = if_addr[17:INDEX_BITS+2];
  assign hit        = rd_valid && (rd_tag == lookup_tag) && !is_uncached(if_addr);

  icache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (lookup_idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (fill_en),
    .wr_idx  (req_idx_q),
    .wr_tag  (req_tag_q),
    .wr_data (mc_inst)
  );

  always_comb begin
    state_d        = state_q;
    if_inst_d      = if_inst_q;
    if_enable_d    = if_enable_q;
    mc_request_d   = mc_request_q;
    mc_addr_d      = mc_addr_q;
    req_idx_d      = req_idx_q;
    req_tag_d      = req_tag_q;
    req_uncached_d = req_uncached_q;
    fill_en        = 1'b0;

    if (rdy) begin
      if_enable_d = 1'b0;
      if (jump_or_not) begin
        // Redirect wins over a same-cycle hit or mc_enable: nothing is filled or returned.
        state_d      = ICACHE_IDLE;
        mc_request_d = 1'b0;
      end else begin
        unique case (state_q)
          ICACHE_IDLE: begin
            // While if_enable is high IF is still presenting the request just answered;
            // ignoring it here keeps the response to a single pulse.
            if (if_request && !if_enable_q) begin
              if (hit) begin
                if_inst_d   = rd_data;
                if_enable_d = 1'b1;
              end else begin
                mc_request_d   = 1'b1;
                mc_addr_d      = {if_addr[AddrLen-1:2], 2'b00};
                req_idx_d      = lookup_idx;
                req_tag_d      = lookup_tag;
                req_uncached_d = is_uncached(if_addr);
                state_d        = ICACHE_MISS;
              end
            end
          end
          ICACHE_MISS: begin
            if (mc_enable) begin
              fill_en      = !req_uncached_q;
              if_inst_d    = mc_inst;
              if_enable_d  = 1'b1;
              mc_request_d = 1'b0;
              state_d      = ICACHE_RESP;
            end
          end
          ICACHE_RESP: begin
            state_d = ICACHE_IDLE;
          end
          default: begin
            state_d = ICACHE_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ICACHE_IDLE;
      if_inst_q      <= ZERO_WORD;
      if_enable_q    <= 1'b0;
      mc_request_q   <= 1'b0;
      mc_addr_q      <= '0;
      req_idx_q      <= '0;
      req_tag_q      <= '0;
      req_uncached_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      if_inst_q      <= if_inst_d;
      if_enable_q    <= if_enable_d;
      mc_request_q   <= mc_request_d;
      mc_addr_q      <= mc_addr_d;
      req_idx_q      <= req_idx_d;
      req_tag_q      <= req_tag_d;
      req_uncached_q <= req_uncached_d;
    end
  end

  assign if_inst    = if_inst_q;
  assign if_enable  = if_enable_q;
  assign mc_request = mc_request_q;
  assign mc_addr    = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Purpose: self-checking bench for icache: directed scenarios plus randomized fetches vs a line-table model.
// Latency: n/a.
// Backpressure: n/a.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        jump_or_not;
  logic        if_request;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_enable;
  logic        mc_request;
  logic [31:0] mc_addr;
  logic [31:0] mc_inst;
  logic        mc_enable;

  int checks = 0;
  int errors = 0;

  // Reference: one entry per line, indexed and tagged with plain address arithmetic.
  bit          mv [128];
  int          mt [128];
  logic [31:0] md [128];

  icache dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .jump_or_not(jump_or_not),
    .if_request (if_request),
    .if_addr    (if_addr),
    .if_inst    (if_inst),
    .if_enable  (if_enable),
    .mc_request (mc_request),
    .mc_addr    (mc_addr),
    .mc_inst    (mc_inst),
    .mc_enable  (mc_enable)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 128);
  endfunction

  function automatic int tag_of(input logic [31:0] a);
    return int'((a >> 9) % 512);
  endfunction

  function automatic bit unc_of(input logic [31:0] a);
    return ((a >> 16) % 4) == 3;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return !unc_of(a) && mv[idx_of(a)] && (mt[idx_of(a)] == tag_of(a));
  endfunction

  function automatic void model_fill(input logic [31:0] a, input logic [31:0] d);
    if (!unc_of(a)) begin
      mv[idx_of(a)] = 1'b1;
      mt[idx_of(a)] = tag_of(a);
      md[idx_of(a)] = d;
    end
  endfunction

  function automatic void model_clear();
    foreach (mv[i]) mv[i] = 1'b0;
  endfunction

  // One complete fetch; d is what memory returns if the model predicts a miss.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input bit stall);
    bit h;
    h = model_hit(a);
    if_addr    = a;
    if_request = 1'b1;
    step();
    if (h) begin
      chk("hit_enable", {31'd0, if_enable}, 32'd1);
      chk("hit_data", if_inst, md[idx_of(a)]);
      chk("hit_no_mc", {31'd0, mc_request}, 32'd0);
    end else begin
      chk("miss_request", {31'd0, mc_request}, 32'd1);
      chk("miss_addr", mc_addr, a & ~32'h3);
      chk("miss_no_enable", {31'd0, if_enable}, 32'd0);
      repeat ($urandom_range(0, 2)) begin
        if_addr = $urandom;
        step();
        chk("miss_hold_req", {31'd0, mc_request}, 32'd1);
        chk("miss_hold_addr", mc_addr, a & ~32'h3);
      end
      if (stall) begin
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
          mc_enable = (i == 2);
          mc_inst   = $urandom;
          step();
          chk("stall_req", {31'd0, mc_request}, 32'd1);
          chk("stall_addr", mc_addr, a & ~32'h3);
          chk("stall_no_enable", {31'd0, if_enable}, 32'd0);
        end
        mc_enable = 1'b0;
        rdy       = 1'b1;
        step();
        chk("post_stall_req", {31'd0, mc_request}, 32'd1);
      end
      mc_inst   = d;
      mc_enable = 1'b1;
      step();
      mc_enable = 1'b0;
      chk("fill_enable", {31'd0, if_enable}, 32'd1);
      chk("fill_data", if_inst, d);
      chk("fill_drop_req", {31'd0, mc_request}, 32'd0);
      model_fill(a, d);
    end
    if_request = 1'b0;
    step();
    chk("single_pulse", {31'd0, if_enable}, 32'd0);
  endtask

  // Redirect: same cycle as a hit, or in the first MISS cycle (optionally with mc_enable).
  task automatic abort(input logic [31:0] a, input bit same_cycle_en);
    if_addr    = a;
    if_request = 1'b1;
    if (model_hit(a)) begin
      jump_or_not = 1'b1;
      step();
      jump_or_not = 1'b0;
      if_request  = 1'b0;
      chk("jump_hit_no_enable", {31'd0, if_enable}, 32'd0);
      chk("jump_hit_no_mc", {31'd0, mc_request}, 32'd0);
    end else begin
      step();
      chk("abort_req", {31'd0, mc_request}, 32'd1);
      jump_or_not = 1'b1;
      if_request  = 1'b0;
      mc_enable   = same_cycle_en;
      mc_inst     = $urandom;
      step();
      jump_or_not = 1'b0;
      mc_enable   = 1'b0;
      chk("abort_drop_req", {31'd0, mc_request}, 32'd0);
      chk("abort_no_enable", {31'd0, if_enable}, 32'd0);
      mc_enable = 1'b1;
      step();
      mc_enable = 1'b0;
      chk("late_no_enable", {31'd0, if_enable}, 32'd0);
      chk("late_no_req", {31'd0, mc_request}, 32'd0);
    end
    step();
    chk("abort_quiet", {31'd0, if_enable}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int unsigned t;
    int unsigned kind;

    rst = 1'b1; rdy = 1'b1; jump_or_not = 1'b0; if_request = 1'b0;
    if_addr = '0; mc_inst = '0; mc_enable = 1'b0;
    model_clear();
    step();
    step();
    chk("reset_if_enable", {31'd0, if_enable}, 32'd0);
    chk("reset_if_inst", if_inst, 32'd0);
    chk("reset_mc_request", {31'd0, mc_request}, 32'd0);
    chk("reset_mc_addr", mc_addr, 32'd0);
    rst = 1'b0;
    step();

    // Cold miss then hit.
    fetch(32'h0000_0000, 32'h0000_0093, 1'b0);
    fetch(32'h0000_0000, 32'hdead_beef, 1'b0);

    // Conflict on index 1.
    fetch(32'h0000_0004, 32'h1111_1111, 1'b0);
    fetch(32'h0000_0204, 32'h2222_2222, 1'b0);
    fetch(32'h0000_0004, 32'h1111_1111, 1'b0);

    // Flush mid-miss, late mc_enable ignored, line still empty.
    abort(32'h0000_0100, 1'b1);
    fetch(32'h0000_0100, 32'h3333_3333, 1'b0);

    // Redirect coinciding with a hit.
    abort(32'h0000_0000, 1'b0);

    // rdy low during MISS with an mc_enable while frozen.
    fetch(32'h0000_0300, 32'h4444_4444, 1'b1);

    // Uncached IO window: always misses, never disturbs index 0.
    fetch(32'h0003_0000, 32'h0000_0055, 1'b0);
    fetch(32'h0003_0000, 32'h0000_0066, 1'b0);
    fetch(32'h0000_0000, 32'h0, 1'b0);

    // Reset in the middle of a miss.
    if_addr    = 32'h0000_0008;
    if_request = 1'b1;
    step();
    chk("rst_miss_req", {31'd0, mc_request}, 32'd1);
    rst        = 1'b1;
    if_request = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_drop_req", {31'd0, mc_request}, 32'd0);
    chk("rst_no_enable", {31'd0, if_enable}, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_mc_addr", mc_addr, 32'd0);
    model_clear();
    fetch(32'h0000_0000, 32'h0000_0077, 1'b0);

    // Randomized traffic over a small working set to mix hits, conflicts, IO and aborts.
    for (int n = 0; n < 200; n++) begin
      t = ($urandom_range(0, 7) == 0) ? (32'h180 + $urandom_range(0, 1)) : $urandom_range(0, 3);
      a = ($urandom_range(0, 3) << 18) | (t << 9) | ($urandom_range(0, 7) << 2);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        abort(a, $urandom_range(0, 1) == 1);
      end else begin
        fetch(a, $urandom, kind == 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the instruction-fetch stage (upstream requester) and the memory controller's instruction port (downstream).
- Hits return the instruction one cycle after the request, with no memory traffic.
- Misses issue a single word fetch to the memory controller, fill the line, and forward the word.
- A taken branch/jump (jump_or_not) aborts any in-flight miss.

Parameters:
- INDEX_BITS, 7, log2 of line count (128 lines × 32 bits).
- TAG_BITS, 16-INDEX_BITS, tag width; the tag covers addr[17:INDEX_BITS+2] because only addr[17:0] is physical.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; when low, all state is frozen.
- jump_or_not  in  1  pipeline redirect/flush from EX.
- if_request  in  1  fetch request from IF, held until if_enable.
- if_addr  in  32  fetch PC, word aligned.
- if_inst  out  32  instruction returned to IF.
- if_enable  out  1  one-cycle pulse; if_inst is valid this cycle.
- mc_request  out  1  word fetch request to the memory controller.
- mc_addr  out  32  word address to the memory controller.
- mc_inst  in  32  word returned by the memory controller.
- mc_enable  in  1  one-cycle pulse; mc_inst is valid.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - All valid bits cleared.
  - State = IDLE.
  - if_enable = 0, if_inst = 0.
  - mc_request = 0, mc_addr = 0.
- Storage:
  - valid[2^INDEX_BITS] in flops; tag and data arrays in regs (inferable as BRAM).
  - Index = if_addr[INDEX_BITS+1:2]; tag = if_addr[17:INDEX_BITS+2].
- Uncached region: addresses with if_addr[17:16]==2'b11 are always treated as a miss and never filled.
- rdy low: no state, register or array changes. Outputs hold. Takes priority over everything except rst.
- States: IDLE, MISS, RESP.
- IDLE, if_request=1, jump_or_not=0:
  - Hit: latch the data word into if_inst and pulse if_enable next cycle (1-cycle hit latency). Stay IDLE.
  - Miss: mc_request=1, mc_addr={if_addr[31:2],2'b00}, latch the request index/tag, go to MISS.
- MISS:
  - Hold mc_request and mc_addr stable until mc_enable.
  - On mc_enable: write data/tag, set valid (unless uncached), if_inst=mc_inst, drop mc_request, go to RESP.
- RESP: if_enable=1 for exactly this cycle, then return to IDLE. New requests are ignored during RESP.
- if_enable is never high for two consecutive cycles of the same request.
- jump_or_not=1 (any state):
  - Next state IDLE; mc_request=0 next cycle.
  - No if_enable pulse for the aborted request.
  - An mc_enable arriving in the same cycle is discarded: no fill, no response. The memory controller drops its own request on the same signal.
- Simultaneous jump_or_not and a hit in IDLE: the hit response is suppressed.
- Line replacement: a miss to an index holding a valid different tag overwrites that line.
- The cache never writes memory; there is no self-modifying-code coherence.
- if_addr changes while in MISS are ignored; the latched address is authoritative.

Decomposition:
- Shared package/config header: AddrLen, InstLen, ZERO_WORD, the IO-region compare constant, and the state encodings ICACHE_IDLE / ICACHE_MISS / ICACHE_RESP.
- One natural sub-module: icache_array (tag+data+valid storage, one read port, one write port, synchronous clear of valid on rst).
- The FSM stays in icache.

Test Plan:
- Reset then request 0x0000_0000 → mc_request=1, mc_addr=0x0. Drive mc_inst=0x0000_0093 with mc_enable → if_enable=1 with if_inst=0x0000_0093 one cycle later. Re-request 0x0 → if_enable next cycle, no mc_request.
- Conflict: fill 0x0000_0004 (data 0x1111_1111), then request 0x0000_0204 (same index for INDEX_BITS=7) → miss. Fill 0x2222_2222. Request 0x4 again → miss again.
- Flush mid-miss: request 0x0000_0100 and assert jump_or_not in the first MISS cycle → mc_request=0 next cycle, no if_enable. A late mc_enable is ignored; a later request to 0x100 still misses.
- rdy low for 5 cycles during MISS with mc_enable arriving while rdy=0 → state, outputs and arrays unchanged. After rdy rises, the fill completes on the next mc_enable.
- Uncached: request 0x0003_0000 twice → both trigger mc_request; valid is never set for that index.
- rst asserted during MISS → next cycle IDLE, mc_request=0, all lines invalid (the previous hit address now misses).
